// File: rtl/shim_trigger_log_reader.sv
// Pops two-word trigger timestamps from an FWFT FIFO, rebuilds the 64-bit value and
// streams either the raw timestamp or a saturated inter-trigger interval.
module shim_trigger_log_reader #(
  parameter int DELTA_WIDTH = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   data_word_rd_en,
  input  logic [31:0]            data_word,
  input  logic                   data_buf_empty,
  input  logic                   mode_delta,
  input  logic                   hist_clear,
  output logic [31:0]            m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [COUNT_WIDTH-1:0] trig_count,
  output logic                   delta_saturated,
  output logic                   non_monotonic
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_CALC, S_OUT_A, S_OUT_B
  } state_t;

  localparam logic [63:0] DELTA_MAX = 64'({DELTA_WIDTH{1'b1}});

  state_t      state;
  logic        mode_r;
  logic        have_prev;
  logic        clear_pending;
  logic [63:0] prev_ts;
  logic [31:0] lo;
  logic [31:0] hi;

  logic [63:0]            ts;
  logic [63:0]            raw_delta;
  logic                   backwards;
  logic                   overflow;
  logic [DELTA_WIDTH-1:0] delta_word;

  function automatic logic [DELTA_WIDTH-1:0] sat_delta(input logic [63:0] d);
    if (d > DELTA_MAX) sat_delta = {DELTA_WIDTH{1'b1}};
    else               sat_delta = d[DELTA_WIDTH-1:0];
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    if (&c) sat_inc = c;
    else    sat_inc = c + 1'b1;
  endfunction

  // Reset gating keeps a mid-record reset from popping a word it would then discard.
  assign data_word_rd_en = !reset && !data_buf_empty &&
                           ((state == S_RD_LO) || (state == S_RD_HI));

  always_comb begin
    ts        = {hi, lo};
    raw_delta = 64'd0;
    backwards = 1'b0;
    if (!have_prev) begin
      raw_delta = ts;
    end else if (ts < prev_ts) begin
      backwards = 1'b1;
    end else begin
      raw_delta = ts - prev_ts;
    end
    overflow   = raw_delta > DELTA_MAX;
    delta_word = sat_delta(raw_delta);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      mode_r          <= 1'b0;
      m_tvalid        <= 1'b0;
      m_tdata         <= 32'd0;
      m_tlast         <= 1'b0;
      trig_count      <= '0;
      delta_saturated <= 1'b0;
      non_monotonic   <= 1'b0;
      have_prev       <= 1'b0;
      prev_ts         <= 64'd0;
      clear_pending   <= 1'b0;
    end else begin
      if (hist_clear && state != S_IDLE) clear_pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (clear_pending || hist_clear) begin
            have_prev     <= 1'b0;
            prev_ts       <= 64'd0;
            trig_count    <= '0;
            clear_pending <= 1'b0;
          end else if (!data_buf_empty) begin
            mode_r <= mode_delta;
            state  <= S_RD_LO;
          end
        end
        S_RD_LO: begin
          if (!data_buf_empty) begin
            lo    <= data_word;
            state <= S_RD_HI;
          end
        end
        S_RD_HI: begin
          if (!data_buf_empty) begin
            hi    <= data_word;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (backwards) non_monotonic   <= 1'b1;
          if (overflow)  delta_saturated <= 1'b1;
          prev_ts    <= ts;
          have_prev  <= 1'b1;
          trig_count <= sat_inc(trig_count);
          m_tdata    <= mode_r ? 32'(delta_word) : lo;
          m_tlast    <= mode_r;
          m_tvalid   <= 1'b1;
          state      <= S_OUT_A;
        end
        S_OUT_A: begin
          if (m_tready) begin
            if (mode_r) begin
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              state    <= S_IDLE;
            end else begin
              m_tdata <= hi;
              m_tlast <= 1'b1;
              state   <= S_OUT_B;
            end
          end
        end
        S_OUT_B: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shim_trigger_log_reader.sv
// Directed bench: behavioural FWFT FIFO feeding the reader, collector on the output stream.
module tb_shim_trigger_log_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_word_rd_en;
  logic [31:0] data_word;
  logic        data_buf_empty;
  logic        mode_delta;
  logic        hist_clear;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [31:0] trig_count;
  logic        delta_saturated;
  logic        non_monotonic;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        flush_req;
  int          pop_cnt = 0;
  int          rd_err = 0;
  logic [31:0] words [64];
  logic        lasts [64];
  int          out_cnt = 0;
  int          hold_err = 0;
  logic        prev_v, prev_hs, prev_l;
  logic [31:0] prev_d;

  always #5 clk = ~clk;

  shim_trigger_log_reader #(.DELTA_WIDTH(32), .COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .data_word_rd_en(data_word_rd_en), .data_word(data_word), .data_buf_empty(data_buf_empty),
    .mode_delta(mode_delta), .hist_clear(hist_clear),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .trig_count(trig_count), .delta_saturated(delta_saturated), .non_monotonic(non_monotonic)
  );

  assign data_word      = mem[rd_ptr % 64];
  assign data_buf_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush_req) begin
      rd_ptr   <= wr_ptr;
      pop_cnt  <= 0;
      out_cnt  <= 0;
      hold_err <= 0;
      prev_v   <= 1'b0;
      prev_hs  <= 1'b0;
      prev_d   <= 32'd0;
      prev_l   <= 1'b0;
    end else begin
      if (data_word_rd_en) begin
        rd_ptr  <= rd_ptr + 1;
        pop_cnt <= pop_cnt + 1;
        if (data_buf_empty) rd_err <= rd_err + 1;
      end
      if (m_tvalid && m_tready) begin
        words[out_cnt % 64] <= m_tdata;
        lasts[out_cnt % 64] <= m_tlast;
        out_cnt <= out_cnt + 1;
      end
      if (!reset && prev_v && !prev_hs &&
          (!m_tvalid || m_tdata != prev_d || m_tlast != prev_l))
        hold_err <= hold_err + 1;
      prev_v  <= m_tvalid && !reset;
      prev_hs <= m_tvalid && m_tready;
      prev_d  <= m_tdata;
      prev_l  <= m_tlast;
    end
  end

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_ts(input logic [63:0] t);
    push_word(t[31:0]);
    push_word(t[63:32]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_req = 1'b1;
    hist_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int c = 0;
    while (out_cnt < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    total++;
    if (out_cnt < n) begin
      bad++;
      $display("FAIL %s timeout: got %0d words, need %0d", name, out_cnt, n);
    end
  endtask

  task automatic test_reset();
    mode_delta = 1'b0;
    m_tready = 1'b1;
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({m_tvalid, m_tlast, data_word_rd_en, delta_saturated, non_monotonic} !== 5'b0 ||
        m_tdata !== 32'd0 || trig_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b last=%b rd=%b data=%h cnt=%0d sat=%b nm=%b, want all 0",
               m_tvalid, m_tlast, data_word_rd_en, m_tdata, trig_count, delta_saturated, non_monotonic);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_raw();
    logic [31:0] exp_w [4];
    logic        exp_l [4];
    exp_w = '{32'h0, 32'h0, 32'h1388, 32'h0};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    mode_delta = 1'b0;
    m_tready = 1'b1;
    push_ts(64'h0);
    push_ts(64'h1388);
    wait_words(4, 60, "raw_words");
    for (int i = 0; i < 4; i++) begin
      total++;
      if (words[i] !== exp_w[i] || lasts[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL raw_word%0d: got %h last=%b, want %h last=%b", i, words[i], lasts[i], exp_w[i], exp_l[i]);
      end
    end
    total++;
    if (trig_count !== 32'd2 || pop_cnt !== 4 || rd_err !== 0) begin
      bad++;
      $display("FAIL raw_counts: trig=%0d pops=%0d empty_pops=%0d, want 2 4 0", trig_count, pop_cnt, rd_err);
    end
  endtask

  task automatic test_delta();
    logic [31:0] exp_w [3];
    exp_w = '{32'd0, 32'd5000, 32'd7000};
    do_reset();
    mode_delta = 1'b1;
    m_tready = 1'b1;
    push_ts(64'd0);
    push_ts(64'd5000);
    push_ts(64'd12000);
    wait_words(3, 60, "delta_words");
    for (int i = 0; i < 3; i++) begin
      total++;
      if (words[i] !== exp_w[i] || lasts[i] !== 1'b1) begin
        bad++;
        $display("FAIL delta_word%0d: got %0d last=%b, want %0d last=1", i, words[i], lasts[i], exp_w[i]);
      end
    end
    total++;
    if (delta_saturated !== 1'b0 || non_monotonic !== 1'b0 || trig_count !== 32'd3 || pop_cnt !== 6) begin
      bad++;
      $display("FAIL delta_flags: sat=%b nm=%b trig=%0d pops=%0d, want 0 0 3 6",
               delta_saturated, non_monotonic, trig_count, pop_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [31:0] exp_w [3];
    exp_w = '{32'h10, 32'hFFFFFFFF, 32'h10};
    do_reset();
    mode_delta = 1'b1;
    m_tready = 1'b1;
    push_ts(64'h0000000000000010);
    push_ts(64'h0000000200000010);
    wait_words(2, 40, "sat_words");
    total++;
    if (delta_saturated !== 1'b1) begin
      bad++;
      $display("FAIL sat_flag_set: got %b, want 1", delta_saturated);
    end
    push_ts(64'h0000000200000020);
    wait_words(3, 40, "sat_words_more");
    for (int i = 0; i < 3; i++) begin
      total++;
      if (words[i] !== exp_w[i]) begin
        bad++;
        $display("FAIL sat_word%0d: got %h, want %h", i, words[i], exp_w[i]);
      end
    end
    total++;
    if (delta_saturated !== 1'b1 || non_monotonic !== 1'b0) begin
      bad++;
      $display("FAIL sat_sticky: sat=%b nm=%b, want 1 0", delta_saturated, non_monotonic);
    end
  endtask

  task automatic test_non_monotonic();
    logic [31:0] exp_w [3];
    exp_w = '{32'd1000, 32'd0, 32'd200};
    do_reset();
    mode_delta = 1'b1;
    m_tready = 1'b1;
    push_ts(64'd1000);
    push_ts(64'd500);
    push_ts(64'd700);
    wait_words(3, 60, "nm_words");
    for (int i = 0; i < 3; i++) begin
      total++;
      if (words[i] !== exp_w[i]) begin
        bad++;
        $display("FAIL nm_word%0d: got %0d, want %0d", i, words[i], exp_w[i]);
      end
    end
    total++;
    if (non_monotonic !== 1'b1 || delta_saturated !== 1'b0) begin
      bad++;
      $display("FAIL nm_flags: nm=%b sat=%b, want 1 0", non_monotonic, delta_saturated);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [6];
    logic        exp_l [6];
    int          stall_bad = 0;
    exp_w = '{32'd1, 32'd0, 32'd2, 32'd0, 32'd3, 32'd0};
    exp_l = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    mode_delta = 1'b0;
    m_tready = 1'b0;
    push_ts(64'd1);
    push_ts(64'd2);
    push_ts(64'd3);
    repeat (6) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_tvalid !== 1'b1 || m_tdata !== 32'd1 || m_tlast !== 1'b0) stall_bad++;
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL stall_hold: %0d stalled cycles wrong (last valid=%b data=%h), want valid=1 data=1",
               stall_bad, m_tvalid, m_tdata);
    end
    total++;
    if (pop_cnt !== 2 || out_cnt !== 0) begin
      bad++;
      $display("FAIL stall_pops: pops=%0d outs=%0d, want 2 0", pop_cnt, out_cnt);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    wait_words(6, 80, "stall_release");
    for (int i = 0; i < 6; i++) begin
      total++;
      if (words[i] !== exp_w[i] || lasts[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL stall_word%0d: got %h last=%b, want %h last=%b", i, words[i], lasts[i], exp_w[i], exp_l[i]);
      end
    end
    total++;
    if (hold_err !== 0 || trig_count !== 32'd3) begin
      bad++;
      $display("FAIL stall_protocol: hold_errs=%0d trig=%0d, want 0 3", hold_err, trig_count);
    end
  endtask

  task automatic test_clear_and_reset_mid();
    int c = 0;
    do_reset();
    mode_delta = 1'b1;
    m_tready = 1'b0;
    push_ts(64'd3000);
    while (m_tvalid !== 1'b1 && c < 30) begin
      @(posedge clk);
      #1;
      c++;
    end
    hist_clear = 1'b1;
    @(posedge clk);
    #1;
    hist_clear = 1'b0;
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'd3000) begin
      bad++;
      $display("FAIL clr_out_a: valid=%b data=%0d, want 1 3000", m_tvalid, m_tdata);
    end
    m_tready = 1'b1;
    wait_words(1, 20, "clr_first");
    push_ts(64'd4000);
    wait_words(2, 40, "clr_second");
    total++;
    if (words[1] !== 32'd4000 || trig_count !== 32'd1) begin
      bad++;
      $display("FAIL clr_restart: word=%0d trig=%0d, want 4000 1", words[1], trig_count);
    end
    push_word(32'd9000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++;
    if (pop_cnt !== 5 || data_word_rd_en !== 1'b0 || m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL mid_wait_hi: pops=%0d rd=%b valid=%b, want 5 0 0", pop_cnt, data_word_rd_en, m_tvalid);
    end
    @(posedge clk);
    #1;
    push_word(32'd0);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (data_word_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_pop: rd=%b, want 0", data_word_rd_en);
    end
    @(negedge clk);
    total++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'd0 || m_tlast !== 1'b0 || trig_count !== 32'd0 ||
        pop_cnt !== 5) begin
      bad++;
      $display("FAIL mid_reset_state: valid=%b data=%h last=%b trig=%0d pops=%0d, want 0 0 0 0 5",
               m_tvalid, m_tdata, m_tlast, trig_count, pop_cnt);
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b1;
    flush_req = 1'b1;
    hist_clear = 1'b0;
    mode_delta = 1'b0;
    m_tready = 1'b0;
    test_reset();
    test_raw();
    test_delta();
    test_saturate();
    test_non_monotonic();
    test_backpressure();
    test_clear_and_reset_mid();
    total++;
    if (rd_err !== 0) begin
      bad++;
      $display("FAIL empty_pops: got %0d, want 0", rd_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
